// File: rtl/muldiv_seq_if.sv
// Core-side bundle of the multiply/divide sequencer: operation request,
// MTHI/MTLO write port, status flags and the HI/LO register pair.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    // Handshake: start is a one-shot request taken only while busy is low.
    // A start seen while busy is dropped, never queued. done pulses for one
    // cycle with HI/LO already holding the result.
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, A, B, hi_we, lo_we, wdata,
        input  busy, done, dbz, HI, LO, dbg_state
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wdata,
        output busy, done, dbz, HI, LO, dbg_state
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: shift-add multiply and
// restoring divide on magnitudes, with the sign applied in a final cycle.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               neg_q, neg_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mul_step, div_step;
    logic [WIDTH-1:0]   quo, rem, rem_fix;

    always_comb begin
        sgn_a = ~bus.op[0] & bus.A[WIDTH-1];
        sgn_b = ~bus.op[0] & bus.B[WIDTH-1];
        mag_a = sgn_a ? -bus.A : bus.A;
        mag_b = sgn_b ? -bus.B : bus.B;

        // Multiply: low half holds the remaining multiplier bits, high half the partial sum.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

        // Divide: high half is the remainder, low half shifts dividend out and quotient in.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, opnd_q};
        div_step = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

        quo = acc_q[WIDTH-1:0];
        rem = acc_q[2*WIDTH-1:WIDTH];
        // With a zero divisor rem ends up as |A|, so restoring A's sign yields raw A.
        rem_fix = sign_a_q ? -rem : rem;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        neg_d    = neg_q;
        bzero_d  = bzero_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    is_div_d = bus.op[1];
                    sign_a_d = sgn_a;
                    neg_d    = sgn_a ^ sgn_b;
                    bzero_d  = (bus.B == '0);
                    opnd_d   = bus.op[1] ? mag_b : mag_a;
                    acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    state_d  = S_RUN;
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d  = bzero_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
                    hi_d  = rem_fix;
                    dbz_d = bzero_q;
                end else begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            bzero_q  <= bzero_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.dbz       = dbz_q;
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, stall rules,
// divide-by-zero, overflow and mid-operation reset.
module tb_muldiv_seq;
  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where busy has dropped.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int nbusy, output logic done_end);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    nbusy = 0;
    while (bus.busy && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
    done_end = bus.done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests_run++; if (bus.dbz !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", bus.dbz); end
    tests_run++; if (bus.HI !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", bus.HI); end
    tests_run++; if (bus.LO !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", bus.LO); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int nb; logic d;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, nb, d);
    tests_run++; if (nb !== 33) begin tests_failed++; $display("FAIL mult_latency: got %0d expected 33", nb); end
    tests_run++; if (d !== 1'b1) begin tests_failed++; $display("FAIL mult_done: got %b expected 1", d); end
    tests_run++; if (bus.HI !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mult_hi: got %h expected ffffffff", bus.HI); end
    tests_run++; if (bus.LO !== 32'hFFFFFFF1) begin tests_failed++; $display("FAIL mult_lo: got %h expected fffffff1", bus.LO); end
    @(negedge clk);
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL done_one_cycle: got %b expected 0", bus.done); end
    run_op(OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, nb, d);
    tests_run++; if (bus.HI !== 32'h0) begin tests_failed++; $display("FAIL mult_negneg_hi: got %h expected 0", bus.HI); end
    tests_run++; if (bus.LO !== 32'd6) begin tests_failed++; $display("FAIL mult_negneg_lo: got %h expected 6", bus.LO); end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, nb, d);
    tests_run++; if (bus.LO !== 32'hFFFFFFFD) begin tests_failed++; $display("FAIL div_pos_neg_lo: got %h expected fffffffd", bus.LO); end
    tests_run++; if (bus.HI !== 32'd1) begin tests_failed++; $display("FAIL div_pos_neg_hi: got %h expected 1", bus.HI); end
  endtask

  task automatic test_back_to_back();
    int nb; logic d;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, d);
    tests_run++; if (bus.HI !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL multu_hi: got %h expected fffffffe", bus.HI); end
    tests_run++; if (bus.LO !== 32'h00000001) begin tests_failed++; $display("FAIL multu_lo: got %h expected 1", bus.LO); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, nb, d);
    tests_run++; if (nb !== 33) begin tests_failed++; $display("FAIL b2b_latency: got %0d expected 33", nb); end
    tests_run++; if (d !== 1'b1) begin tests_failed++; $display("FAIL b2b_done: got %b expected 1", d); end
    tests_run++; if (bus.LO !== 32'hFFFFFFFD) begin tests_failed++; $display("FAIL b2b_div_lo: got %h expected fffffffd", bus.LO); end
    tests_run++; if (bus.HI !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL b2b_div_hi: got %h expected ffffffff", bus.HI); end
  endtask

  task automatic test_dbz();
    int nb; logic d;
    run_op(OP_DIVU, 32'd7, 32'd0, nb, d);
    tests_run++; if (nb !== 33) begin tests_failed++; $display("FAIL dbz_latency: got %0d expected 33", nb); end
    tests_run++; if (bus.LO !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL dbz_lo: got %h expected ffffffff", bus.LO); end
    tests_run++; if (bus.HI !== 32'd7) begin tests_failed++; $display("FAIL dbz_hi: got %h expected 7", bus.HI); end
    tests_run++; if (bus.dbz !== 1'b1) begin tests_failed++; $display("FAIL dbz_flag: got %b expected 1", bus.dbz); end
    repeat (3) @(negedge clk);
    tests_run++; if (bus.dbz !== 1'b1) begin tests_failed++; $display("FAIL dbz_held: got %b expected 1", bus.dbz); end
    bus.start = 1'b1; bus.op = OP_MULTU; bus.A = 32'd2; bus.B = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++; if (bus.dbz !== 1'b0) begin tests_failed++; $display("FAIL dbz_clear_at_start: got %b expected 0", bus.dbz); end
    nb = 0;
    while (bus.busy && nb < 100) begin nb++; @(negedge clk); end
    tests_run++; if (nb !== 33) begin tests_failed++; $display("FAIL dbz_next_latency: got %0d expected 33", nb); end
    tests_run++; if (bus.LO !== 32'd6) begin tests_failed++; $display("FAIL dbz_next_lo: got %h expected 6", bus.LO); end
    tests_run++; if (bus.HI !== 32'd0) begin tests_failed++; $display("FAIL dbz_next_hi: got %h expected 0", bus.HI); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, nb, d);
    tests_run++; if (bus.LO !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL sdbz_lo: got %h expected ffffffff", bus.LO); end
    tests_run++; if (bus.HI !== 32'hFFFFFFF9) begin tests_failed++; $display("FAIL sdbz_hi: got %h expected fffffff9", bus.HI); end
    tests_run++; if (bus.dbz !== 1'b1) begin tests_failed++; $display("FAIL sdbz_flag: got %b expected 1", bus.dbz); end
  endtask

  task automatic test_overflow();
    int nb; logic d;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nb, d);
    tests_run++; if (bus.LO !== 32'h80000000) begin tests_failed++; $display("FAIL ovf_lo: got %h expected 80000000", bus.LO); end
    tests_run++; if (bus.HI !== 32'h0) begin tests_failed++; $display("FAIL ovf_hi: got %h expected 0", bus.HI); end
    tests_run++; if (bus.dbz !== 1'b0) begin tests_failed++; $display("FAIL ovf_dbz: got %b expected 0", bus.dbz); end
  endtask

  task automatic test_stall();
    int nb; int ndone; logic d;
    bus.start = 1'b1; bus.op = OP_MULTU; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    nb = bus.busy ? 1 : 0;
    ndone = 0;
    for (int c = 0; c < 45; c++) begin
      if (c == 4) begin
        bus.start = 1'b1; bus.op = OP_MULT; bus.A = 32'd7; bus.B = 32'd7;
        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
      end else begin
        bus.start = 1'b0; bus.lo_we = 1'b0;
      end
      @(negedge clk);
      if (bus.busy) nb++;
      if (bus.done) ndone++;
    end
    tests_run++; if (nb !== 33) begin tests_failed++; $display("FAIL stall_busy_cycles: got %0d expected 33", nb); end
    tests_run++; if (ndone !== 1) begin tests_failed++; $display("FAIL stall_done_count: got %0d expected 1", ndone); end
    tests_run++; if (bus.LO !== 32'd12) begin tests_failed++; $display("FAIL stall_lo: got %h expected c", bus.LO); end
    tests_run++; if (bus.HI !== 32'd0) begin tests_failed++; $display("FAIL stall_hi: got %h expected 0", bus.HI); end

    bus.lo_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    tests_run++; if (bus.LO !== 32'h1234) begin tests_failed++; $display("FAIL mtlo_lo: got %h expected 1234", bus.LO); end
    tests_run++; if (bus.HI !== 32'd0) begin tests_failed++; $display("FAIL mtlo_hi_kept: got %h expected 0", bus.HI); end

    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h55AA55AA;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    tests_run++; if (bus.HI !== 32'h55AA55AA) begin tests_failed++; $display("FAIL mthi_both_hi: got %h expected 55aa55aa", bus.HI); end
    tests_run++; if (bus.LO !== 32'h55AA55AA) begin tests_failed++; $display("FAIL mtlo_both_lo: got %h expected 55aa55aa", bus.LO); end

    bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    run_op(OP_MULTU, 32'd5, 32'd6, nb, d);
    bus.hi_we = 1'b0;
    tests_run++; if (bus.HI !== 32'd0) begin tests_failed++; $display("FAIL start_wins_hi: got %h expected 0", bus.HI); end
    tests_run++; if (bus.LO !== 32'd30) begin tests_failed++; $display("FAIL start_wins_lo: got %h expected 1e", bus.LO); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    bus.start = 1'b1; bus.op = OP_DIV; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_done: got %b expected 0", bus.done); end
    tests_run++; if (bus.HI !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_hi: got %h expected 0", bus.HI); end
    tests_run++; if (bus.LO !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_lo: got %h expected 0", bus.LO); end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    tests_run++; if (ndone !== 0) begin tests_failed++; $display("FAIL rst_mid_no_done: got %0d expected 0", ndone); end
    tests_run++; if (bus.LO !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_lo_after: got %h expected 0", bus.LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_dbz();
    test_overflow();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the single-cycle MIPS core.
- Sits beside the 32-bit ALU in the execute path. The core issues MULT/MULTU/DIV/DIVU here instead of to the ALU.
- Holds the core stalled via busy while it iterates. MFHI/MFLO read HI/LO directly; MTHI/MTLO write them through this block.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits, product 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  rs operand: multiplicand or dividend.
- B  input  WIDTH  rt operand: multiplier or divisor.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress; core must stall HI/LO users.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- dbz  output  1  last divide had B==0; held until the next accepted start.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; the reset port is named reset.
- Reset values: HI=0, LO=0, busy=0, done=0, dbz=0, state=IDLE, counter=0. Reset mid-operation aborts the operation immediately with no HI/LO update.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 at edge k: latch op, the sign flags, and |A|, |B|. Magnitudes are taken only when op[0]==0; otherwise raw values are used.
  - Also at edge k: clear dbz, counter=0, busy=1, go to RUN.
  - Without start, hi_we/lo_we load wdata into HI/LO at the edge; both may write in the same cycle.
  - If start and hi_we/lo_we are asserted together, start wins and the write is dropped.
- RUN: one iteration per cycle for WIDTH cycles (edges k+1..k+WIDTH), then go to FIX.
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator. The adder is WIDTH+1 bits so carry is kept.
  - Divide: restoring division on magnitudes. The partial remainder is WIDTH+1 bits; each iteration does a trial subtract, and the borrow selects the quotient bit.
- FIX, edge k+WIDTH+1:
  - Signed multiply: negate the 64-bit product if sign(A)!=sign(B).
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of A.
  - Write HI=upper half / remainder and LO=lower half / quotient.
  - Set done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: busy is high for WIDTH+1 cycles (33 cycles at default). Results are visible on HI/LO the cycle done is high.
- While busy:
  - start is ignored (not queued).
  - hi_we/lo_we are ignored (dropped).
  - A/B/op changes have no effect.
- Divide by zero:
  - Takes the same full latency.
  - Sign fix-up is bypassed: LO=all ones, HI=A (raw).
  - dbz=1 at the FIX edge, held until the next accepted start.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, dbz=0. No trap.
- MULTU/DIVU treat operands as unsigned with no fix-up.
- Back-to-back: a start in the cycle done is high is accepted (the state is IDLE).

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5 -> after 33 busy cycles: done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then DIV A=0xFFFFFFF9 (-7), B=2 started in the done cycle -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7, dbz=1. Next MULTU 2*3 -> dbz clears at the start edge; LO=6, HI=0.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, dbz=0.
- Stall rules:
  - A second start 5 cycles into an operation is ignored: busy stays 33 cycles total and there is exactly one done.
  - lo_we=1, wdata=0x1234 mid-operation is dropped.
  - The same lo_we write in IDLE -> LO=0x1234 next cycle.
  - start and hi_we together in IDLE -> hi_we is dropped, HI=operation result.
- Reset asserted 10 cycles into a DIV -> next cycle busy=0, done=0, HI=LO=0. No done pulse follows.
